// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Requester side of the instruction-memory port. Holds the PC and issues one
//   word fetch per cycle. The memory answers one cycle after each request.
//   Returned words are queued with their PCs and handed to decode over a
//   valid/ready handshake. A flush redirects fetch to a branch or jump target.
//
// Ports
//   if_clk        in   clock, rising edge
//   if_rst        in   asynchronous active-low reset
//   if_i_flush    in   redirect request (1-cycle pulse)
//   if_i_target   in   redirect byte address; the low 2 bits are dropped
//   if_o_im_ce    out  fetch request to instruction memory
//   if_o_im_addr  out  fetch byte address (word aligned)
//   if_i_im_ce    in   memory response valid, one cycle after the request
//   if_i_im_instr in   memory response data
//   if_o_valid    out  head instruction available to decode
//   if_o_instr    out  head instruction, 0 when the queue is empty
//   if_o_pc       out  head PC, 0 when the queue is empty
//   if_i_ready    in   decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned         PC_WIDTH  = 32,
   parameter int unsigned         IWIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned         BUF_DEPTH = 2
) (
   input  logic                if_clk,
   input  logic                if_rst,
   input  logic                if_i_flush,
   input  logic [PC_WIDTH-1:0] if_i_target,
   output logic                if_o_im_ce,
   output logic [PC_WIDTH-1:0] if_o_im_addr,
   input  logic                if_i_im_ce,
   input  logic [IWIDTH-1:0]   if_i_im_instr,
   output logic                if_o_valid,
   output logic [IWIDTH-1:0]   if_o_instr,
   output logic [PC_WIDTH-1:0] if_o_pc,
   input  logic                if_i_ready
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;   // PC of the request in flight
   logic                inflight_q, inflight_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [PC_WIDTH-1:0] buf_pc    [BUF_DEPTH];
   logic [IWIDTH-1:0]   buf_instr [BUF_DEPTH];

   logic                not_empty;
   logic                pop;
   logic                push;
   logic                issue;
   logic [CNT_W:0]      occupancy;            // entries committed after this cycle
   logic                target_lo_unused;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign target_lo_unused = ^if_i_target[1:0];

   assign not_empty  = (count_q != '0);
   assign if_o_valid = not_empty & ~if_i_flush;
   assign pop        = if_o_valid & if_i_ready;

   // A response only counts when a request is outstanding; a flush drops it.
   assign push = if_i_im_ce & inflight_q & ~if_i_flush;

   // Reserve a queue slot for every outstanding request so the response can
   // always be absorbed, even while decode is stalled.
   assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
   assign issue     = if_rst & ~if_i_flush & (occupancy < DEPTH_C);

   assign if_o_im_ce   = issue;
   assign if_o_im_addr = pc_q;
   assign if_o_instr   = not_empty ? buf_instr[rd_ptr_q] : '0;
   assign if_o_pc      = not_empty ? buf_pc[rd_ptr_q]    : '0;

   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (if_i_flush) begin
         pc_d       = {if_i_target[PC_WIDTH-1:2], 2'b00};
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            pc_d     = pc_q + PC_WIDTH'(4);    // wraps modulo 2^PC_WIDTH
            req_pc_d = pc_q;
         end
         inflight_d = issue | (inflight_q & ~if_i_im_ce);
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge if_clk or negedge if_rst) begin
      if (!if_rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage carries no reset; count_q alone marks entries as valid.
   always_ff @(posedge if_clk) begin
      if (push) begin
         buf_pc[wr_ptr_q]    <= req_pc_q;
         buf_instr[wr_ptr_q] <= if_i_im_instr;
      end
   end

   // Responses must line up exactly with outstanding requests.
   a_im_protocol: assert property (@(posedge if_clk) disable iff (!if_rst)
                                   (if_i_im_ce == inflight_q));

endmodule
